sm83_oam_dma: RTL

SM83_OAM_DMA -- requirements
Module: sm83_oam_dma

---
 rtl/sm83_pkg.sv | 30 +++
 rtl/sm83_hram.sv | 27 ++
 rtl/sm83_oam_dma.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sm83_pkg.sv
// Shared SM83 types and OAM DMA constants.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package sm83_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    localparam addr_t       DMA_REG_ADDR = 16'hFF46;
    localparam addr_t       OAM_BASE     = 16'hFE00;
    localparam addr_t       HRAM_BASE    = 16'hFF80;
    localparam addr_t       HRAM_LAST    = 16'hFFFE;
    localparam int unsigned DMA_LEN      = 160;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_START,
        DMA_ACTIVE
    } dma_state_t;

    function automatic logic is_hram(input addr_t a);
        return (a >= HRAM_BASE) && (a <= HRAM_LAST);
    endfunction

    // Sources in E0-FF land on echo RAM, which mirrors C0-DF.
    function automatic data_t dma_src_map(input data_t hi);
        return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
    endfunction

endpackage

// File: rtl/sm83_hram.sv
// 127x8 high RAM (FF80-FFFE); asynchronous read, synchronous write, contents not reset.
// Latency: read combinational, write lands on the next clk rising edge.
// Backpressure: none, always ready.
// Ports: clk; we/w_addr/w_data write port; r_addr/r_data read port (addresses are the low 7 bits).
module sm83_hram
    import sm83_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] w_addr,
    input  data_t      w_data,
    input  logic [6:0] r_addr,
    output data_t      r_data
);

    data_t mem [0:126];

    // Index 7F corresponds to FFFF (interrupt enable), which is not HRAM.
    always_ff @(posedge clk) begin
        if (we && (w_addr != 7'h7F)) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = (r_addr == 7'h7F) ? 8'h00 : mem[r_addr];

endmodule

// File: rtl/sm83_oam_dma.sv
// SM83 OAM DMA: sits between core and bus, copies 160 bytes from {src,00} to FE00 on an FF46 write.
// Latency: one START cycle after the FF46 write, then 160 ACTIVE cycles, one byte per cycle.
// Backpressure: none; while ACTIVE the core is locked out (reads FF, writes dropped) except FF46 and HRAM.
// Optional HRAM: define OAM_DMA_HRAM_EN to serve FF80-FFFE internally in every state.
// Ports: clk, rst_n (async, active-low); core_* core side; bus_* bus side; dma_active high in ACTIVE.
module sm83_oam_dma
    import sm83_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  addr_t core_r_addr,
    input  addr_t core_w_addr,
    input  data_t core_w_data,
    input  logic  core_w_wen,
    output data_t core_r_data,
    output addr_t bus_r_addr,
    output addr_t bus_w_addr,
    output data_t bus_w_data,
    output logic  bus_w_wen,
    input  data_t bus_r_data,
    output logic  dma_active
);

    dma_state_t state;
    logic [7:0] idx;
    data_t      dma_reg;

    logic  reg_wr;
    logic  idx_last;
    data_t src_hi;
    addr_t dma_rd_addr;
    addr_t dma_wr_addr;

    logic  hram_r_hit;
    logic  hram_w_hit;
    data_t hram_r_data;

    assign reg_wr      = core_w_wen && (core_w_addr == DMA_REG_ADDR);
    assign idx_last    = (idx == 8'(DMA_LEN - 1));
    assign src_hi      = dma_src_map(dma_reg);
    assign dma_rd_addr = {src_hi, 8'h00} + {8'h00, idx};
    assign dma_wr_addr = OAM_BASE + {8'h00, idx};

`ifdef OAM_DMA_HRAM_EN
    assign hram_r_hit = is_hram(core_r_addr);
    assign hram_w_hit = is_hram(core_w_addr);

    sm83_hram u_hram (
        .clk    (clk),
        .we     (core_w_wen && hram_w_hit),
        .w_addr (core_w_addr[6:0]),
        .w_data (core_w_data),
        .r_addr (core_r_addr[6:0]),
        .r_data (hram_r_data)
    );
`else
    assign hram_r_hit  = 1'b0;
    assign hram_w_hit  = 1'b0;
    assign hram_r_data = 8'h00;
`endif

    // An FF46 write always restarts through START, even mid-transfer; the
    // in-flight byte of that cycle still completes since the DMA owns the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DMA_IDLE;
            idx        <= 8'h00;
            dma_reg    <= 8'hFF;
            dma_active <= 1'b0;
        end else begin
            if (reg_wr) begin
                dma_reg    <= core_w_data;
                state      <= DMA_START;
                idx        <= 8'h00;
                dma_active <= 1'b0;
            end else begin
                case (state)
                    DMA_START: begin
                        state      <= DMA_ACTIVE;
                        idx        <= 8'h00;
                        dma_active <= 1'b1;
                    end
                    DMA_ACTIVE: begin
                        if (idx_last) begin
                            state      <= DMA_IDLE;
                            idx        <= 8'h00;
                            dma_active <= 1'b0;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                    default: begin
                        state      <= DMA_IDLE;
                        dma_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Priority for core reads: FF46 register, then HRAM, then the DMA lockout, then the bus.
    always_comb begin
        bus_r_addr  = core_r_addr;
        bus_w_addr  = core_w_addr;
        bus_w_data  = core_w_data;
        bus_w_wen   = core_w_wen && !reg_wr && !hram_w_hit;
        core_r_data = bus_r_data;

        if (state == DMA_ACTIVE) begin
            bus_r_addr  = dma_rd_addr;
            bus_w_addr  = dma_wr_addr;
            bus_w_data  = bus_r_data;
            bus_w_wen   = 1'b1;
            core_r_data = 8'hFF;
        end

        if (hram_r_hit) begin
            core_r_data = hram_r_data;
        end

        if (core_r_addr == DMA_REG_ADDR) begin
            core_r_data = dma_reg;
        end
    end

endmodule
